// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, counts retirements.
// Optional feature: define MCU_JUMP_EN to decode opcode 000010 as a jump; otherwise it traps.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Strobes are registered from the next state; only the FETCH ir/pc loads follow mem_ready live.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
`ifdef MCU_JUMP_EN
            JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           cur, nxt;
    ctrl_t            ctrl_q;
    logic             illegal_q;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        case (cur)
            FETCH:  if (mem_ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:          nxt = EXEC;
                    OP_LW, OP_SW:  nxt = MEMADR;
                    OP_BEQ:        nxt = BRANCH;
`ifdef MCU_JUMP_EN
                    OP_J:          nxt = JUMP;
`endif
                    default:       nxt = TRAP;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      nxt = MEMRD;
                else if (opcode == OP_SW) nxt = MEMWR;
                else                      nxt = TRAP;
            end
            MEMRD:  if (mem_ready) nxt = MEMWB;
            MEMWR:  if (mem_ready) begin nxt = FETCH; retire = 1'b1; end
            EXEC:   nxt = RWB;
            MEMWB, RWB, BRANCH, JUMP: begin nxt = FETCH; retire = 1'b1; end
            TRAP:   nxt = TRAP;
            default: nxt = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= FETCH;
            ctrl_q    <= state_ctrl(FETCH);
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            cur    <= nxt;
            ctrl_q <= state_ctrl(nxt);
            if (nxt == TRAP) illegal_q <= 1'b1;
            if (retire)      count_q   <= count_q + 1'b1;
        end
    end

    // Everything but the state is held low while reset is asserted, including its first cycle.
    logic fetch_ld;
    assign fetch_ld      = (cur == FETCH) & mem_ready & ~rst;
    assign pc_write      = (ctrl_q.pc_write & ~rst) | fetch_ld;
    assign ir_write      = fetch_ld;
    assign pc_write_cond = ctrl_q.pc_write_cond & ~rst;
    assign i_or_d        = ctrl_q.i_or_d & ~rst;
    assign mem_read      = ctrl_q.mem_read & ~rst;
    assign mem_write     = ctrl_q.mem_write & ~rst;
    assign mem_to_reg    = ctrl_q.mem_to_reg & ~rst;
    assign reg_dst       = ctrl_q.reg_dst & ~rst;
    assign reg_write     = ctrl_q.reg_write & ~rst;
    assign alu_src_a     = ctrl_q.alu_src_a & ~rst;
    assign alu_src_b     = rst ? 2'b00 : ctrl_q.alu_src_b;
    assign alu_op        = rst ? 2'b00 : ctrl_q.alu_op;
    assign pc_source     = rst ? 2'b00 : ctrl_q.pc_source;
    assign illegal       = illegal_q & ~rst;
    assign retired       = rst ? '0 : count_q;
    assign state         = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued from a spec model, compared each cycle.
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RWB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_TRAP = 4'd15;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [3:0] retired;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } strb_t;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        strb_t      strb;
        logic       ill;
        logic [3:0] ret;
    } cyc_t;

    cyc_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       ill_m = 1'b0;
    logic [3:0] ret_m = 4'd0;
    logic [3:0] last_st = S_FETCH;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic strb_t exp_strb(input logic [3:0] st, input logic mr);
        strb_t s;
        s = '0;
        case (st)
            S_FETCH:  begin s.mem_read = 1; s.alu_src_b = 2'b01; s.ir_write = mr; s.pc_write = mr; end
            S_DECODE: s.alu_src_b = 2'b11;
            S_MEMADR: begin s.alu_src_a = 1; s.alu_src_b = 2'b10; end
            S_MEMRD:  begin s.mem_read = 1; s.i_or_d = 1; end
            S_MEMWB:  begin s.reg_write = 1; s.mem_to_reg = 1; end
            S_MEMWR:  begin s.mem_write = 1; s.i_or_d = 1; end
            S_EXEC:   begin s.alu_src_a = 1; s.alu_op = 2'b10; end
            S_RWB:    begin s.reg_write = 1; s.reg_dst = 1; end
            S_BRANCH: begin s.alu_src_a = 1; s.alu_op = 2'b01; s.pc_write_cond = 1; s.pc_source = 2'b01; end
            S_JUMP:   begin s.pc_write = 1; s.pc_source = 2'b10; end
            default:  s = '0;
        endcase
        return s;
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
`ifdef MCU_JUMP_EN
        if (op == OP_J) return 1'b1;
`endif
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic mr);
        cyc_t e;
        e.r = 1'b0; e.op = op; e.mr = mr; e.st = st;
        e.strb = exp_strb(st, mr); e.ill = ill_m; e.ret = ret_m;
        sbq.push_back(e);
        last_st = st;
        if (st == S_MEMWB || st == S_RWB || st == S_BRANCH || st == S_JUMP || (st == S_MEMWR && mr))
            ret_m = ret_m + 4'd1;
        if (st == S_DECODE && !op_legal(op)) ill_m = 1'b1;
    endtask

    task automatic push_rst(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e.r = 1'b1; e.op = 6'd0; e.mr = 1'b1;
            e.st = (i == 0 && last_st == S_TRAP) ? S_TRAP : S_FETCH;
            e.strb = '0; e.ill = 1'b0; e.ret = 4'd0;
            sbq.push_back(e);
        end
        ill_m = 1'b0; ret_m = 4'd0; last_st = S_FETCH;
    endtask

    // One instruction from FETCH: fst fetch wait cycles, mst memory wait cycles.
    task automatic instr(input logic [5:0] op, input int fst, input int mst);
        for (int i = 0; i < fst; i++) push(S_FETCH, op, 1'b0);
        push(S_FETCH, op, 1'b1);
        push(S_DECODE, op, 1'b1);
        if (!op_legal(op)) begin
            for (int i = 0; i < 20; i++) push(S_TRAP, op, 1'b1);
        end else begin
            case (op)
                OP_R:   begin push(S_EXEC, op, 1'b1); push(S_RWB, op, 1'b1); end
                OP_LW:  begin
                    push(S_MEMADR, op, 1'b1);
                    for (int i = 0; i < mst; i++) push(S_MEMRD, op, 1'b0);
                    push(S_MEMRD, op, 1'b1);
                    push(S_MEMWB, op, 1'b1);
                end
                OP_SW:  begin
                    push(S_MEMADR, op, 1'b1);
                    for (int i = 0; i < mst; i++) push(S_MEMWR, op, 1'b0);
                    push(S_MEMWR, op, 1'b1);
                end
                OP_BEQ: push(S_BRANCH, op, 1'b1);
                default: push(S_JUMP, op, 1'b1);
            endcase
        end
    endtask

    initial begin
        cyc_t e;
        push_rst(2);
        instr(OP_R, 0, 0);
        instr(OP_LW, 0, 2);
        instr(OP_SW, 0, 0);
        instr(OP_BEQ, 0, 0);
        instr(OP_SW, 0, 1);
        instr(OP_R, 2, 0);
        instr(OP_J, 0, 0);
        if (last_st == S_TRAP) push_rst(1);
        for (int i = 0; i < 16; i++) instr(OP_R, 0, 0);
        instr(OP_BAD, 0, 0);
        push_rst(2);
        instr(OP_LW, 1, 0);

        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk);
            #1;
            rst = e.r; opcode = e.op; mem_ready = e.mr;
            @(negedge clk);
            chk("state", {28'd0, state}, {28'd0, e.st});
            chk("strobes", {16'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source},
                           {16'd0, e.strb});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("retired", {28'd0, retired}, {28'd0, e.ret});
            chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
